// File: rtl/la_pkg.sv
// la_pkg: shared encodings for the logic-analyser capture engine.
//   - trigger mode encodings driven on la_capture_core.mode
//   - capture FSM state type
package la_pkg;

    localparam logic [1:0] LA_MODE_LEVEL = 2'd0;
    localparam logic [1:0] LA_MODE_RISE  = 2'd1;
    localparam logic [1:0] LA_MODE_FALL  = 2'd2;
    localparam logic [1:0] LA_MODE_IMM   = 2'd3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PREFILL   = 3'd1,
        WAIT_TRIG = 3'd2,
        POST      = 3'd3,
        DONE      = 3'd4
    } la_state_e;

endpackage

// File: rtl/la_trig_eval.sv
// la_trig_eval: combinational trigger condition for one strobed sample.
// Ports:
//   sample     - probe value being strobed this cycle
//   prev       - previously strobed sample (edge reference)
//   mode       - LA_MODE_* encoding
//   mask/value - level-mode compare mask and required values
//   chan       - channel watched by the edge modes
//   edge_valid - prev holds a real sample from the current capture
//   fire       - trigger condition true for this sample
module la_trig_eval
    import la_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int CW       = 3
) (
    input  logic [CHANNELS-1:0] sample,
    input  logic [CHANNELS-1:0] prev,
    input  logic [1:0]          mode,
    input  logic [CHANNELS-1:0] mask,
    input  logic [CHANNELS-1:0] value,
    input  logic [CW-1:0]       chan,
    input  logic                edge_valid,
    output logic                fire
);

    logic cur_bit;
    logic prv_bit;

    always_comb begin
        cur_bit = sample[chan];
        prv_bit = prev[chan];
        fire    = 1'b0;
        case (mode)
            LA_MODE_LEVEL: fire = (((sample ^ value) & mask) == '0);
            LA_MODE_RISE:  fire = edge_valid & ~prv_bit &  cur_bit;
            LA_MODE_FALL:  fire = edge_valid &  prv_bit & ~cur_bit;
            default:       fire = 1'b1;
        endcase
    end

endmodule

// File: rtl/la_capture_core.sv
// la_capture_core: pre-triggered capture engine for the tiny logic analyser.
// Samples `probe` every div+1 cycles into a DEPTH-word circular buffer,
// keeps PRE samples ahead of the trigger and reads back oldest-first.
// Ports:
//   clk, rst_n           - clock, async active-low reset
//   probe                - synchronised signals under test
//   arm, abort           - single-cycle start / cancel pulses
//   mode                 - trigger mode (LA_MODE_*)
//   trig_mask/trig_value - level trigger compare
//   trig_chan            - edge trigger channel
//   div                  - sample period minus one
//   rd_addr / rd_data    - readout index (0 = oldest) / registered word
//   busy, triggered, done - capture status
module la_capture_core
    import la_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int DEPTH    = 16,
    parameter int PRE      = 4
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic [CHANNELS-1:0]                             probe,
    input  logic                                            arm,
    input  logic                                            abort,
    input  logic [1:0]                                      mode,
    input  logic [CHANNELS-1:0]                             trig_mask,
    input  logic [CHANNELS-1:0]                             trig_value,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] trig_chan,
    input  logic [7:0]                                      div,
    input  logic [$clog2(DEPTH)-1:0]                        rd_addr,
    output logic [CHANNELS-1:0]                             rd_data,
    output logic                                            busy,
    output logic                                            triggered,
    output logic                                            done
);

    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int POST_N = DEPTH - PRE - 1;
    localparam int CNTW   = AW + 1;
    localparam logic [CNTW-1:0] PRE_LAST  = CNTW'((PRE > 0) ? PRE - 1 : 0);
    localparam logic [CNTW-1:0] POST_LAST = CNTW'((POST_N > 0) ? POST_N - 1 : 0);

    la_state_e           state, state_nxt;
    logic [7:0]          presc;
    logic                strobe;
    logic                start;
    logic                fire;
    logic                hit;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       trig_ptr;
    logic [AW-1:0]       rd_idx;
    logic [CNTW-1:0]     cnt;
    logic [CHANNELS-1:0] prev_sample;
    logic                edge_valid;
    logic [CHANNELS-1:0] mem [DEPTH];

    assign busy   = (state == PREFILL) || (state == WAIT_TRIG) || (state == POST);
    assign done   = (state == DONE);
    // abort takes priority, so a simultaneous arm never starts a capture
    assign start  = arm && !abort && ((state == IDLE) || (state == DONE));
    assign strobe = busy && (presc == 8'd0);
    assign hit    = (state == WAIT_TRIG) && strobe && fire;
    // oldest retained sample sits PRE words behind the trigger sample
    assign rd_idx = trig_ptr - AW'(PRE) + rd_addr;

    la_trig_eval #(
        .CHANNELS (CHANNELS),
        .CW       (CW)
    ) u_trig (
        .sample     (probe),
        .prev       (prev_sample),
        .mode       (mode),
        .mask       (trig_mask),
        .value      (trig_value),
        .chan       (trig_chan),
        .edge_valid (edge_valid),
        .fire       (fire)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = (PRE == 0) ? WAIT_TRIG : PREFILL;
            PREFILL:    if (strobe && cnt == PRE_LAST) state_nxt = WAIT_TRIG;
            WAIT_TRIG:  if (hit) state_nxt = (POST_N == 0) ? DONE : POST;
            POST:       if (strobe && cnt == POST_LAST) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            presc       <= 8'd0;
            wr_ptr      <= '0;
            trig_ptr    <= '0;
            cnt         <= '0;
            prev_sample <= '0;
            edge_valid  <= 1'b0;
            triggered   <= 1'b0;
            rd_data     <= '0;
        end else begin
            state   <= state_nxt;
            rd_data <= mem[rd_idx];

            if (abort || start) triggered <= 1'b0;
            else if (hit)       triggered <= 1'b1;

            // loading zero makes the very next cycle a strobe
            if (start)     presc <= 8'd0;
            else if (busy) presc <= (presc == 8'd0) ? div : presc - 8'd1;

            if (start) begin
                edge_valid <= 1'b0;
                cnt        <= '0;
            end else if (strobe) begin
                wr_ptr      <= wr_ptr + AW'(1);
                prev_sample <= probe;
                edge_valid  <= 1'b1;
                // WAIT_TRIG zeroes the count so POST starts from 0
                cnt <= (state == WAIT_TRIG) ? '0 : cnt + CNTW'(1);
            end

            if (hit) trig_ptr <= wr_ptr;
        end
    end

    // sample buffer: no reset, contents only meaningful once done
    always_ff @(posedge clk) begin
        if (strobe) mem[wr_ptr] <= probe;
    end

endmodule

// File: tb/tb_la_capture_core.sv
// Bench for la_capture_core: three builds (PRE=4, PRE=0, PRE=15) share
// stimulus. probe is a free-running counter restarting at 0 after arm.
// Delays are counted in clock edges from the arm edge to the first edge
// after which done reads 1.
module tb_la_capture_core;
    import la_pkg::*;

    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [7:0]      probe = 8'h00;
    logic            arm = 1'b0;
    logic            abort = 1'b0;
    logic [1:0]      mode = 2'd0;
    logic [7:0]      trig_mask = 8'h00;
    logic [7:0]      trig_value = 8'h00;
    logic [2:0]      trig_chan = 3'd0;
    logic [7:0]      div = 8'd0;
    logic [3:0]      rd_addr = 4'd0;
    logic [2:0][7:0] rdd;
    logic [2:0]      bsy, trg, dn;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int arm_cyc = 0;

    la_capture_core #(.CHANNELS(8), .DEPTH(16), .PRE(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .probe(probe), .arm(arm), .abort(abort), .mode(mode),
        .trig_mask(trig_mask), .trig_value(trig_value), .trig_chan(trig_chan), .div(div),
        .rd_addr(rd_addr), .rd_data(rdd[0]), .busy(bsy[0]), .triggered(trg[0]), .done(dn[0]));
    la_capture_core #(.CHANNELS(8), .DEPTH(16), .PRE(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .probe(probe), .arm(arm), .abort(abort), .mode(mode),
        .trig_mask(trig_mask), .trig_value(trig_value), .trig_chan(trig_chan), .div(div),
        .rd_addr(rd_addr), .rd_data(rdd[1]), .busy(bsy[1]), .triggered(trg[1]), .done(dn[1]));
    la_capture_core #(.CHANNELS(8), .DEPTH(16), .PRE(15)) dut2 (
        .clk(clk), .rst_n(rst_n), .probe(probe), .arm(arm), .abort(abort), .mode(mode),
        .trig_mask(trig_mask), .trig_value(trig_value), .trig_chan(trig_chan), .div(div),
        .rd_addr(rd_addr), .rd_data(rdd[2]), .busy(bsy[2]), .triggered(trg[2]), .done(dn[2]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) probe <= arm ? 8'h00 : probe + 8'h01;

    typedef struct {
        string      name;
        logic [1:0] mode;
        logic [7:0] mask;
        logic [7:0] value;
        logic [2:0] chan;
        logic [7:0] div;
        logic [2:0] which;
        logic [7:0] st0, st1, st2;
        int         step;
        int         dly0, dly1, dly2;
    } vec_t;

    typedef struct {
        int         dut;
        int         idx;
        logic [7:0] exp;
    } sb_t;

    vec_t vecs[4];
    sb_t  sbq[$];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic start_run();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        arm   = 1'b1;
        @(negedge clk);
        arm     = 1'b0;
        arm_cyc = cyc;
    endtask

    // waits (bounded) for done on each selected build; -1 means timed out
    task automatic wait_done(input logic [2:0] which, output int d0, output int d1, output int d2);
        int got[3];
        got = '{-1, -1, -1};
        for (int k = 0; k < 200; k++) begin
            for (int d = 0; d < 3; d++)
                if (dn[d] && got[d] < 0) got[d] = cyc - arm_cyc;
            if ((!which[0] || got[0] >= 0) && (!which[1] || got[1] >= 0) &&
                (!which[2] || got[2] >= 0)) break;
            @(negedge clk);
        end
        d0 = got[0];
        d1 = got[1];
        d2 = got[2];
    endtask

    // drive rd_addr 0..DEPTH-1, expectations queued at drive time,
    // compared one cycle later when the registered word appears
    task automatic readback(input logic [2:0] which, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input int step);
        sb_t e;
        logic [7:0] st[3];
        st[0] = s0; st[1] = s1; st[2] = s2;
        for (int i = 0; i <= DEPTH; i++) begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                check($sformatf("rd_data dut%0d addr%0d", e.dut, e.idx), int'(rdd[e.dut]), int'(e.exp));
            end
            if (i < DEPTH) begin
                rd_addr = 4'(i);
                for (int d = 0; d < 3; d++) begin
                    if (which[d]) begin
                        e.dut = d;
                        e.idx = i;
                        e.exp = st[d] + 8'(step * i);
                        sbq.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic setup(input logic [1:0] m, input logic [7:0] mk, input logic [7:0] v,
                         input logic [2:0] ch, input logic [7:0] dv);
        mode = m; trig_mask = mk; trig_value = v; trig_chan = ch; div = dv;
    endtask

    initial begin
        int d0, d1, d2;

        vecs[0] = '{"level20", LA_MODE_LEVEL, 8'hFF, 8'h20, 3'd0, 8'd0, 3'b111,
                    8'h1C, 8'h20, 8'h11, 1, 44, 48, 33};
        vecs[1] = '{"rise3", LA_MODE_RISE, 8'h00, 8'h00, 3'd3, 8'd0, 3'b001,
                    8'h04, 8'h00, 8'h00, 1, 20, 0, 0};
        vecs[2] = '{"fall3", LA_MODE_FALL, 8'h00, 8'h00, 3'd3, 8'd0, 3'b001,
                    8'h0C, 8'h00, 8'h00, 1, 28, 0, 0};
        vecs[3] = '{"imm_div2", LA_MODE_IMM, 8'h00, 8'h00, 3'd0, 8'd2, 3'b001,
                    8'h00, 8'h00, 8'h00, 3, 46, 0, 0};

        // reset state
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset busy%0d", d), int'(bsy[d]), 0);
            check($sformatf("reset triggered%0d", d), int'(trg[d]), 0);
            check($sformatf("reset done%0d", d), int'(dn[d]), 0);
            check($sformatf("reset rd_data%0d", d), int'(rdd[d]), 0);
        end
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            setup(vecs[v].mode, vecs[v].mask, vecs[v].value, vecs[v].chan, vecs[v].div);
            start_run();
            check({vecs[v].name, " busy after arm"}, int'(bsy[0]), 1);
            wait_done(vecs[v].which, d0, d1, d2);
            check({vecs[v].name, " done delay dut0"}, d0, vecs[v].dly0);
            if (vecs[v].which[1]) check({vecs[v].name, " done delay dut1"}, d1, vecs[v].dly1);
            if (vecs[v].which[2]) check({vecs[v].name, " done delay dut2"}, d2, vecs[v].dly2);
            check({vecs[v].name, " triggered"}, int'(trg[0]), 1);
            check({vecs[v].name, " busy at done"}, int'(bsy[0]), 0);
            readback(vecs[v].which, vecs[v].st0, vecs[v].st1, vecs[v].st2, vecs[v].step);
        end

        // abort mid-capture: level on 0xFF never fires in 10 cycles
        setup(LA_MODE_LEVEL, 8'hFF, 8'hFF, 3'd0, 8'd0);
        start_run();
        repeat (9) @(negedge clk);
        check("abort pre busy", int'(bsy[0]), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort busy", int'(bsy[0]), 0);
        check("abort triggered", int'(trg[0]), 0);
        check("abort done", int'(dn[0]), 0);
        arm = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("arm+abort busy c%0d", k), int'(bsy[0]), 0);
            @(negedge clk);
        end

        // reset while in POST, then a normal capture
        setup(LA_MODE_LEVEL, 8'hFF, 8'h20, 3'd0, 8'd0);
        start_run();
        for (int k = 0; k < 100 && !trg[0]; k++) @(negedge clk);
        check("post triggered", int'(trg[0]), 1);
        @(negedge clk);
        check("post busy", int'(bsy[0]), 1);
        rst_n = 1'b0;
        #1;
        check("rst busy", int'(bsy[0]), 0);
        check("rst triggered", int'(trg[0]), 0);
        check("rst done", int'(dn[0]), 0);
        check("rst rd_data", int'(rdd[0]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        start_run();
        wait_done(3'b001, d0, d1, d2);
        check("rearm done delay", d0, 44);
        readback(3'b001, 8'h1C, 8'h00, 8'h00, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
